alu_serial: RTL and testbench
=============================

# alu_serial

Parametrised multi-precision ALU for the 6502 datapath family. Operands are WIDTH = 8*SLICES bits wide. The block processes them one 8-bit slice per clock through a single 8-bit ALU slice, chaining carry between slices. It uses the same 6-bit opcode as the 8-bit ALU: shift-right, mode and S3..S0 in 74181 active-high function-table form. It adds a start/busy/done handshake, registered results, and Z/N/V flags that the 8-bit ALU does not provide. Typical use is 16/24/32-bit address and microcode arithmetic without widening the combinational carry chain.

## Interface
- SLICES, 2, number of 8-bit slices; WIDTH = 8*SLICES; legal range 1..8
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  request; sampled only in IDLE
- A  in  WIDTH  operand A; sampled with accepted start
- B  in  WIDTH  operand B; sampled with accepted start
- CI  in  1  carry in, or shift-in bit for shift-right; sampled with accepted start
- OP  in  6  {sr, mode, s3..s0}; sampled with accepted start
- busy  out  1  high while an operation is in progress
- done  out  1  one-cycle pulse when results update
- F  out  WIDTH  result; holds until the next completion
- CO  out  1  carry out of the full-width operation
- Z  out  1  F == 0
- N  out  1  F[WIDTH-1]
- V  out  1  signed overflow; add/sub only

## Operation
- State machine: IDLE, RUN.
- IDLE, start=1:
  - Latch A, B, CI and OP into internal registers.
  - Set slice index to the first slice.
  - Go to RUN; busy=1 from the next cycle.
- RUN processes one slice per cycle:
  - Arithmetic and logic modes (OP[5]=0):
    - Order is LSB slice first.
    - The slice carry-in is CI for slice 0, otherwise the registered carry-out of the previous slice.
  - Shift-right (OP[5]=1):
    - Order is MSB slice first.
    - The slice shift-in is CI for the top slice, otherwise bit 0 of the previously processed (higher) slice.
    - Slice result is {shift-in, slice[7:1]}.
    - Carry-out is slice bit 0.
- Slice function for OP[5]=0: 74181 active-high table with active-high carry. Required codes:
  - M=0, S=1001: A plus B plus CI.
  - M=0, S=0110: A minus B minus 1 plus CI. CO=1 means no borrow.
  - M=1, S=1011: A AND B.
  - M=1, S=1110: A OR B.
  - M=1, S=0110: A XOR B.
  - M=1, S=0000: NOT A.
  - Other codes follow the same table.
- Final results, on the last slice:
  - F is written with all slices and CO with the final carry.
  - Z and N are derived from the full F.
  - CO is forced to 0 when M=1 and OP[5]=0.
  - V for M=0, S=1001: (A_msb==B_msb) & (F_msb!=A_msb).
  - V for M=0, S=0110: (A_msb!=B_msb) & (F_msb!=A_msb).
  - V is 0 for all other opcodes.
- F, CO, Z, N and V change only on completion. Partial results are never visible.
- start while busy is ignored; no queueing.
- Input changes while busy have no effect.

## Timing
- Reset values: busy=0, done=0, F=0, CO=0, Z=0, N=0, V=0, state IDLE.
- Reset mid-operation:
  - Abort on the next edge; result outputs return to 0.
  - No done pulse is produced.
- Latency:
  - start accepted at edge t.
  - busy=1 during the SLICES cycles after edge t.
  - At edge t+SLICES, F/CO/Z/N/V update, done=1 and busy=0.
  - done=1 lasts exactly one cycle.
- Back-to-back: start is accepted in the done cycle, since state is IDLE, giving one result every SLICES cycles.
- Throughput: one operation per SLICES cycles.
- SLICES=1: a single-cycle registered 8-bit ALU with done one cycle after start.
- Slice carry and shift-in are registered between cycles. Critical path is one 8-bit slice plus flag logic.

## Test plan
All scenarios use SLICES=2.

- Add carry across slices:
  - Stimulus: A=0x12FF, B=0x0001, CI=0, OP=0b001001.
  - Response: F=0x1300, CO=0, Z=0, N=0, V=0; done pulses at edge t+2, busy high 2 cycles.
- Signed overflow and borrow:
  - Add: A=0x7FFF, B=0x0001, CI=0, OP=0b001001 -> F=0x8000, N=1, V=1, CO=0.
  - Subtract: A=0x0000, B=0x0001, CI=1, OP=0b000110 -> F=0xFFFF, CO=0, N=1, V=0.
- Shift-right:
  - Stimulus: A=0x0301, CI=1, OP=0b100000.
  - Response: F=0x8180, CO=1. Bit 0 of the high byte enters bit 7 of the low byte.
- Logic and zero flag:
  - Stimulus: A=0xF0F0, B=0xF0F0, OP=0b010110 (XOR).
  - Response: F=0x0000, Z=1, CO=0, V=0.
- Handshake:
  - Stimulus: second start during busy with different operands.
  - Response: ignored; result is from the first operation only.
  - Stimulus: start in the done cycle.
  - Response: accepted; next done 2 cycles later.
- Reset mid-operation:
  - Stimulus: assert reset one cycle after start.
  - Response: busy=0, F=0, no done; a subsequent start completes normally.

Source files
------------

// File: rtl/alu_serial.sv
// Multi-precision 74181-style ALU that walks WIDTH = 8*SLICES bit operands one
// byte per clock through a single 8-bit slice, with registered results and flags.
module alu_serial #(
  parameter  int SLICES = 2,
  localparam int WIDTH  = 8 * SLICES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CI,
  input  logic [5:0]       OP,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] F,
  output logic             CO,
  output logic             Z,
  output logic             N,
  output logic             V,
  output logic             dbg_state
);

  // Handshake: start is taken only while idle (operands, CI and OP captured on
  // that edge); busy is high for the SLICES cycles that follow; done is a single
  // cycle pulse coinciding with the result update, and start may be taken again
  // in that same cycle. start while busy is dropped, never queued.

  localparam int            IW   = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [IW-1:0] LAST = IW'(SLICES - 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, acc_q;
  logic [5:0]       op_q;
  logic             carry_q;
  logic [IW-1:0]    idx_q;

  logic [7:0]       a_s, b_s, x_s, y_s, slice_f;
  logic [8:0]       sum9;
  logic             slice_co, last_slice, is_add, is_sub, v_full, co_full;
  logic [WIDTH-1:0] f_full;

  // One 74181 slice: F(arith) = X plus Y plus carry; F(logic) = NOT(X xor Y).
  always_comb begin
    a_s     = a_q[8*idx_q +: 8];
    b_s     = b_q[8*idx_q +: 8];
    x_s     = a_s | (b_s & {8{op_q[0]}}) | (~b_s & {8{op_q[1]}});
    y_s     = (a_s & b_s & {8{op_q[3]}}) | (a_s & ~b_s & {8{op_q[2]}});
    sum9    = {1'b0, x_s} + {1'b0, y_s} + {8'b0, carry_q};
    slice_f = sum9[7:0];
    slice_co = sum9[8];
    if (op_q[5]) begin
      // carry_q holds the shift-in bit coming down from the higher slice
      slice_f  = {carry_q, a_s[7:1]};
      slice_co = a_s[0];
    end else if (op_q[4]) begin
      slice_f  = ~(x_s ^ y_s);
      slice_co = 1'b0;
    end
  end

  always_comb begin
    f_full                = acc_q;
    f_full[8*idx_q +: 8]  = slice_f;
    last_slice = op_q[5] ? (idx_q == '0) : (idx_q == LAST);
    is_add     = (op_q == 6'b001001);
    is_sub     = (op_q == 6'b000110);
    v_full     = 1'b0;
    if (is_add)
      v_full = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (f_full[WIDTH-1] != a_q[WIDTH-1]);
    else if (is_sub)
      v_full = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (f_full[WIDTH-1] != a_q[WIDTH-1]);
    co_full = (op_q[5] || !op_q[4]) ? slice_co : 1'b0;
  end

  always_comb begin
    state_d   = state_q;
    busy      = 1'b0;
    dbg_state = state_q;
    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        busy = 1'b1;
        if (last_slice) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      op_q    <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      done    <= 1'b0;
      F       <= '0;
      CO      <= 1'b0;
      Z       <= 1'b0;
      N       <= 1'b0;
      V       <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= A;
            b_q     <= B;
            op_q    <= OP;
            carry_q <= CI;
            acc_q   <= '0;
            idx_q   <= OP[5] ? LAST : '0;
          end
        end
        RUN: begin
          acc_q   <= f_full;
          carry_q <= slice_co;
          idx_q   <= op_q[5] ? idx_q - 1'b1 : idx_q + 1'b1;
          if (last_slice) begin
            F    <= f_full;
            CO   <= co_full;
            Z    <= (f_full == '0);
            N    <= f_full[WIDTH-1];
            V    <= v_full;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_serial.sv
// Directed bench for alu_serial (SLICES=2): vector table plus handshake,
// back-to-back and mid-operation reset sequences.
module tb_alu_serial;

  localparam int SLICES = 2;
  localparam int W      = 8 * SLICES;

  logic         clk, reset, start, CI;
  logic [W-1:0] A, B;
  logic [5:0]   OP;
  logic         busy, done, CO, Z, N, V, dbg_state;
  logic [W-1:0] F;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  alu_serial #(.SLICES(SLICES)) dut (
    .clk(clk), .reset(reset), .start(start), .A(A), .B(B), .CI(CI), .OP(OP),
    .busy(busy), .done(done), .F(F), .CO(CO), .Z(Z), .N(N), .V(V),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic [5:0]   op;
    logic [W-1:0] f;
    logic         co;
    logic         z;
    logic         n;
    logic         v;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver: called at a negedge; returns at the negedge right after the accept edge
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ci, input logic [5:0] op);
    A = a; B = b; CI = ci; OP = op; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // counts accept-relative edges until done, bounded
  task automatic wait_done(output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = 0;
    while (!done && lat < 20) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    check("done_timeout", done, 1'b1);
  endtask

  initial begin
    int lat, bc, dcnt;
    logic [W-1:0] exp_f;

    vecs[0]  = '{16'h12FF, 16'h0001, 1'b0, 6'b001001, 16'h1300, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{16'h7FFF, 16'h0001, 1'b0, 6'b001001, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[2]  = '{16'h0000, 16'h0001, 1'b1, 6'b000110, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{16'h0301, 16'h0000, 1'b1, 6'b100000, 16'h8180, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{16'hF0F0, 16'hF0F0, 1'b0, 6'b010110, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{16'h1234, 16'hFF0F, 1'b0, 6'b011011, 16'h1204, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{16'h8001, 16'h0100, 1'b0, 6'b011110, 16'h8101, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{16'h00FF, 16'h1234, 1'b1, 6'b010000, 16'hFF00, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{16'hFFFF, 16'h0001, 1'b0, 6'b001001, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{16'h5000, 16'h1000, 1'b1, 6'b000110, 16'h4000, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{16'h8000, 16'h0001, 1'b1, 6'b000110, 16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{16'h00FF, 16'h0000, 1'b1, 6'b001001, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{16'h8000, 16'h0000, 1'b0, 6'b100000, 16'h4000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{16'h8000, 16'h8000, 1'b0, 6'b001001, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[14] = '{16'h0100, 16'h0000, 1'b0, 6'b001111, 16'h00FF, 1'b1, 1'b0, 1'b0, 1'b0};

    reset = 1'b1; start = 1'b0; A = '0; B = '0; CI = 1'b0; OP = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_F", F, 16'h0000);
    check("rst_flags", {CO, Z, N, V}, 4'b0000);
    check("rst_state", dbg_state, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    // table-driven vectors
    for (int i = 0; i < 15; i++) begin
      launch(vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].op);
      check($sformatf("v%0d_state_run", i), dbg_state, 1'b1);
      wait_done(lat, bc);
      check($sformatf("v%0d_latency", i), lat, SLICES);
      check($sformatf("v%0d_busy_cycles", i), bc, SLICES);
      check($sformatf("v%0d_busy_at_done", i), busy, 1'b0);
      check($sformatf("v%0d_F", i), F, vecs[i].f);
      check($sformatf("v%0d_CO", i), CO, vecs[i].co);
      check($sformatf("v%0d_Z", i), Z, vecs[i].z);
      check($sformatf("v%0d_N", i), N, vecs[i].n);
      check($sformatf("v%0d_V", i), V, vecs[i].v);
      @(negedge clk);
      check($sformatf("v%0d_done_pulse", i), done, 1'b0);
    end

    // start while busy is ignored
    launch(16'h12FF, 16'h0001, 1'b0, 6'b001001);
    exp_q.push_back(16'h1300);
    A = 16'hAAAA; B = 16'h5555; CI = 1'b1; OP = 6'b011110; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bc);
    exp_f = exp_q.pop_front();
    check("busy_start_F", F, exp_f);
    check("busy_start_CO", CO, 1'b0);
    @(negedge clk);
    check("busy_start_not_queued", busy, 1'b0);
    check("busy_start_no_done", done, 1'b0);

    // back-to-back: start in the done cycle
    launch(16'h0100, 16'h0001, 1'b1, 6'b000110);
    exp_q.push_back(16'h00FF);
    wait_done(lat, bc);
    exp_f = exp_q.pop_front();
    check("b2b_first_F", F, exp_f);
    check("b2b_first_CO", CO, 1'b1);
    launch(16'h4000, 16'h4000, 1'b0, 6'b001001);
    exp_q.push_back(16'h8000);
    check("b2b_accepted", busy, 1'b1);
    check("b2b_partial_hidden", F, 16'h00FF);
    wait_done(lat, bc);
    check("b2b_latency", lat, SLICES);
    exp_f = exp_q.pop_front();
    check("b2b_second_F", F, exp_f);
    check("b2b_second_NV", {N, V, CO}, 3'b110);

    // reset one cycle after start
    @(negedge clk);
    launch(16'h7FFF, 16'h0001, 1'b0, 6'b001001);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_F", F, 16'h0000);
    check("mid_rst_flags", {CO, Z, N, V}, 4'b0000);
    check("mid_rst_state", dbg_state, 1'b0);
    reset = 1'b0;
    dcnt = 0;
    for (int k = 0; k < 4; k++) begin
      if (done) dcnt++;
      @(negedge clk);
    end
    check("mid_rst_no_done", dcnt, 0);
    launch(16'h0001, 16'h0001, 1'b0, 6'b001001);
    wait_done(lat, bc);
    check("post_rst_latency", lat, SLICES);
    check("post_rst_F", F, 16'h0002);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
